// File: rtl/fft_pkg.sv
// fft_pkg: shared types and helpers for the FFT butterfly datapath.
//   LAT        - pipeline latency of fft_bfly_pipe (input transfer to out_valid).
//   WMAX       - working width of the helper functions; wide enough for any
//                sensible DW/TW combination so no helper ever wraps internally.
//   round_shift- arithmetic right shift, optionally round-half-up.
//   sat_round  - round_shift followed by reduction to dw bits (clamp or wrap),
//                reporting whether the value left the dw range.
//   cpx_re/cpx_im/cpx_pack - {re, im} complex word unpack/pack helpers.
package fft_pkg;

  localparam int LAT  = 3;
  localparam int WMAX = 128;

  typedef logic signed [WMAX-1:0] wide_t;

  typedef struct packed {
    wide_t val;
    logic  ovf;
  } sr_t;

  // Sign-extend the low dw bits of v to the full working width.
  function automatic wide_t sext(input wide_t v, input int dw);
    wide_t t;
    t = v <<< (WMAX - dw);
    return t >>> (WMAX - dw);
  endfunction

  // Shift right by 'shift'; with rnd set, add half an LSB first (round half up).
  function automatic wide_t round_shift(input wide_t v, input int shift, input bit rnd);
    wide_t bias;
    bias = '0;
    if (rnd && shift > 0)
      bias = wide_t'(1) <<< (shift - 1);
    return (v + bias) >>> shift;
  endfunction

  function automatic sr_t sat_round(input wide_t value, input int shift,
                                    input bit rnd, input bit sat, input int dw);
    sr_t   r;
    wide_t s;
    wide_t hi;
    wide_t lo;
    s     = round_shift(value, shift, rnd);
    hi    = (wide_t'(1) <<< (dw - 1)) - wide_t'(1);
    lo    = -(wide_t'(1) <<< (dw - 1));
    r.ovf = (s > hi) || (s < lo);
    if (!r.ovf)
      r.val = s;
    else if (sat)
      r.val = (s > hi) ? hi : lo;
    else
      r.val = sext(s, dw);
    return r;
  endfunction

  function automatic wide_t cpx_re(input logic [WMAX-1:0] w, input int dw);
    return sext(wide_t'(w >> dw), dw);
  endfunction

  function automatic wide_t cpx_im(input logic [WMAX-1:0] w, input int dw);
    return sext(wide_t'(w), dw);
  endfunction

  function automatic logic [WMAX-1:0] cpx_pack(input wide_t re, input wide_t im, input int dw);
    logic [WMAX-1:0] mask;
    mask = (WMAX'(1) << dw) - WMAX'(1);
    return ((re & mask) << dw) | (im & mask);
  endfunction

endpackage

// File: rtl/cmul_pipe.sv
// cmul_pipe: registered full-precision complex multiply r = p * w.
//   clk        - clock
//   en         - load enable (low holds the result register)
//   p_re, p_im - signed AW-bit operand
//   w_re, w_im - signed BW-bit twiddle
//   r_re, r_im - signed (AW+BW+1)-bit registered product, no rounding
module cmul_pipe #(
  parameter int AW = 17,
  parameter int BW = 32
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic signed [AW-1:0] p_re,
  input  logic signed [AW-1:0] p_im,
  input  logic signed [BW-1:0] w_re,
  input  logic signed [BW-1:0] w_im,
  output logic signed [AW+BW:0] r_re,
  output logic signed [AW+BW:0] r_im
);

  localparam int MW = AW + BW;
  localparam int RW = AW + BW + 1;

  logic signed [MW-1:0] m_rr;
  logic signed [MW-1:0] m_ii;
  logic signed [MW-1:0] m_ri;
  logic signed [MW-1:0] m_ir;

  assign m_rr = MW'(p_re) * MW'(w_re);
  assign m_ii = MW'(p_im) * MW'(w_im);
  assign m_ri = MW'(p_re) * MW'(w_im);
  assign m_ir = MW'(p_im) * MW'(w_re);

  always_ff @(posedge clk) begin
    if (en) begin
      r_re <= RW'(m_rr) - RW'(m_ii);
      r_im <= RW'(m_ri) + RW'(m_ir);
    end
  end

endmodule

// File: rtl/fft_bfly_pipe.sv
// fft_bfly_pipe: fully pipelined radix-2 complex butterfly, 3 stages.
//   clk, rst            - clock, asynchronous active-high reset
//   in_valid/in_ready   - input handshake; a, b {re,im}, w_re/w_im, mode
//                         (0 DIF, 1 DIT) and scale are taken on transfer
//   out_valid/out_ready - output handshake; x, y {re,im} registered results
//   ovf, ovf_clr        - sticky range-exceeded flag and its clear
// Stage 1 registers operands and the DIF sum/difference, stage 2 is the
// complex multiply, stage 3 rounds, finishes DIT add/sub, scales, reduces.
module fft_bfly_pipe import fft_pkg::*; #(
  parameter int DW    = 16,
  parameter int TW    = 32,
  parameter int TF    = 16,
  parameter int ROUND = 0,
  parameter int SAT   = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*DW-1:0] a,
  input  logic [2*DW-1:0] b,
  input  logic [TW-1:0]   w_re,
  input  logic [TW-1:0]   w_im,
  input  logic            mode,
  input  logic            scale,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*DW-1:0] x,
  output logic [2*DW-1:0] y,
  output logic            ovf,
  input  logic            ovf_clr
);

  localparam int PW   = DW + 1;        // sum/difference width
  localparam int MW   = PW + TW + 1;   // full complex product width
  localparam bit RND  = (ROUND != 0);
  localparam bit SATB = (SAT != 0);

  // One global stall: every stage moves together, so a bubble never blocks.
  logic en;
  assign en       = ~(out_valid & ~out_ready);
  assign in_ready = en;

  logic signed [DW-1:0] a_re, a_im, b_re, b_im;
  assign a_re = DW'(cpx_re(WMAX'(a), DW));
  assign a_im = DW'(cpx_im(WMAX'(a), DW));
  assign b_re = DW'(cpx_re(WMAX'(b), DW));
  assign b_im = DW'(cpx_im(WMAX'(b), DW));

  // ---------------- Stage 1 ----------------
  logic                 s1_valid_reg, s1_mode_reg, s1_scale_reg;
  logic signed [DW-1:0] s1_a_re_reg, s1_a_im_reg;
  logic signed [PW-1:0] s1_sum_re_reg, s1_sum_im_reg;
  logic signed [PW-1:0] s1_p_re_reg, s1_p_im_reg;
  logic signed [TW-1:0] s1_w_re_reg, s1_w_im_reg;

  logic signed [PW-1:0] sum_re_next, sum_im_next, p_re_next, p_im_next;

  always_comb begin
    sum_re_next = PW'(a_re) + PW'(b_re);
    sum_im_next = PW'(a_im) + PW'(b_im);
    // DIF multiplies the difference; DIT multiplies b itself.
    p_re_next   = mode ? PW'(b_re) : PW'(a_re) - PW'(b_re);
    p_im_next   = mode ? PW'(b_im) : PW'(a_im) - PW'(b_im);
  end

  // ---------------- Stage 2 ----------------
  logic                 s2_valid_reg, s2_mode_reg, s2_scale_reg;
  logic signed [DW-1:0] s2_a_re_reg, s2_a_im_reg;
  logic signed [PW-1:0] s2_sum_re_reg, s2_sum_im_reg;
  logic signed [MW-1:0] s2_prod_re, s2_prod_im;

  cmul_pipe #(.AW(PW), .BW(TW)) u_cmul (
    .clk  (clk),
    .en   (en),
    .p_re (s1_p_re_reg),
    .p_im (s1_p_im_reg),
    .w_re (s1_w_re_reg),
    .w_im (s1_w_im_reg),
    .r_re (s2_prod_re),
    .r_im (s2_prod_im)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
    end else if (en) begin
      s1_valid_reg <= in_valid;
      s2_valid_reg <= s1_valid_reg;
    end
  end

  // Datapath registers carry no reset; their content is qualified by valids.
  always_ff @(posedge clk) begin
    if (en) begin
      s1_mode_reg   <= mode;
      s1_scale_reg  <= scale;
      s1_a_re_reg   <= a_re;
      s1_a_im_reg   <= a_im;
      s1_sum_re_reg <= sum_re_next;
      s1_sum_im_reg <= sum_im_next;
      s1_p_re_reg   <= p_re_next;
      s1_p_im_reg   <= p_im_next;
      s1_w_re_reg   <= w_re;
      s1_w_im_reg   <= w_im;
      s2_mode_reg   <= s1_mode_reg;
      s2_scale_reg  <= s1_scale_reg;
      s2_a_re_reg   <= s1_a_re_reg;
      s2_a_im_reg   <= s1_a_im_reg;
      s2_sum_re_reg <= s1_sum_re_reg;
      s2_sum_im_reg <= s1_sum_im_reg;
    end
  end

  // ---------------- Stage 3 ----------------
  wide_t q_re, q_im;
  wide_t pre [4];   // x_re, x_im, y_re, y_im before scaling/reduction

  always_comb begin
    q_re = round_shift(wide_t'(s2_prod_re), TF, RND);
    q_im = round_shift(wide_t'(s2_prod_im), TF, RND);
    if (s2_mode_reg) begin
      pre[0] = wide_t'(s2_a_re_reg) + q_re;
      pre[1] = wide_t'(s2_a_im_reg) + q_im;
      pre[2] = wide_t'(s2_a_re_reg) - q_re;
      pre[3] = wide_t'(s2_a_im_reg) - q_im;
    end else begin
      pre[0] = wide_t'(s2_sum_re_reg);
      pre[1] = wide_t'(s2_sum_im_reg);
      pre[2] = q_re;
      pre[3] = q_im;
    end
  end

  logic signed [DW-1:0] res [4];
  logic [3:0]           ovf_bits;

  for (genvar gi = 0; gi < 4; gi++) begin : g_sat
    sr_t sr;
    assign sr           = sat_round(pre[gi], s2_scale_reg ? 1 : 0, RND, SATB, DW);
    assign res[gi]      = DW'(sr.val);
    assign ovf_bits[gi] = sr.ovf;
  end

  logic [2*DW-1:0] x_next, y_next;
  assign x_next = (2*DW)'(cpx_pack(wide_t'(res[0]), wide_t'(res[1]), DW));
  assign y_next = (2*DW)'(cpx_pack(wide_t'(res[2]), wide_t'(res[3]), DW));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      x         <= '0;
      y         <= '0;
      ovf       <= 1'b0;
    end else begin
      if (en) begin
        out_valid <= s2_valid_reg;
        x         <= x_next;
        y         <= y_next;
      end
      // A new overflow event outranks a simultaneous clear.
      if (en && s2_valid_reg && (|ovf_bits))
        ovf <= 1'b1;
      else if (ovf_clr)
        ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_bfly_pipe.sv
// Bench: four instances (ROUND x SAT) share one stimulus stream; a scoreboard
// of arithmetic-model results is compared against every presented output.
module tb_fft_bfly_pipe;

  localparam int DW = 16;
  localparam int TW = 32;
  localparam int TF = 16;
  localparam int NI = 4;   // instance k: ROUND = k%2, SAT = k/2

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            in_valid = 1'b0;
  logic            out_ready = 1'b1;
  logic            mode = 1'b0;
  logic            scale = 1'b0;
  logic            ovf_clr = 1'b0;
  logic [2*DW-1:0] a = '0;
  logic [2*DW-1:0] b = '0;
  logic [TW-1:0]   w_re = '0;
  logic [TW-1:0]   w_im = '0;

  logic            in_ready [NI];
  logic            out_valid [NI];
  logic            ovf [NI];
  logic [2*DW-1:0] x [NI];
  logic [2*DW-1:0] y [NI];

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    fft_bfly_pipe #(.DW(DW), .TW(TW), .TF(TF), .ROUND(gi % 2), .SAT(gi / 2)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready[gi]),
      .a         (a),
      .b         (b),
      .w_re      (w_re),
      .w_im      (w_im),
      .mode      (mode),
      .scale     (scale),
      .out_valid (out_valid[gi]),
      .out_ready (out_ready),
      .x         (x[gi]),
      .y         (y[gi]),
      .ovf       (ovf[gi]),
      .ovf_clr   (ovf_clr)
    );
  end

  int errors = 0;
  int checks = 0;

  function automatic void check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic longint sx(input logic [DW-1:0] v);
    return longint'($signed(v));
  endfunction

  // ---------------- behavioural model ----------------
  function automatic longint rs(input longint v, input int s, input bit rnd);
    if (s == 0) return v;
    if (rnd) v = v + (longint'(1) <<< (s - 1));
    return v >>> s;
  endfunction

  function automatic longint red(input longint v, input bit sat, inout bit ov);
    longint hi, lo, m;
    hi = (longint'(1) <<< (DW - 1)) - 1;
    lo = -hi - 1;
    if (v >= lo && v <= hi) return v;
    ov = 1'b1;
    if (sat) return (v > hi) ? hi : lo;
    m = v & ((longint'(1) <<< DW) - 1);
    if (m > hi) m = m - (longint'(1) <<< DW);
    return m;
  endfunction

  function automatic void model(input longint ar, ai, br, bi, wr, wi,
                                input bit md, sc, rnd, sat,
                                output logic [2*DW-1:0] xo, yo, output bit ov);
    longint v [4];
    longint pr, pi, qr, qi;
    if (!md) begin
      v[0] = ar + br;
      v[1] = ai + bi;
      pr   = (ar - br) * wr - (ai - bi) * wi;
      pi   = (ar - br) * wi + (ai - bi) * wr;
      v[2] = rs(pr, TF, rnd);
      v[3] = rs(pi, TF, rnd);
    end else begin
      pr   = br * wr - bi * wi;
      pi   = br * wi + bi * wr;
      qr   = rs(pr, TF, rnd);
      qi   = rs(pi, TF, rnd);
      v[0] = ar + qr;
      v[1] = ai + qi;
      v[2] = ar - qr;
      v[3] = ai - qi;
    end
    ov = 1'b0;
    for (int i = 0; i < 4; i++)
      v[i] = red(rs(v[i], sc ? 1 : 0, rnd), sat, ov);
    xo = {DW'(v[0]), DW'(v[1])};
    yo = {DW'(v[2]), DW'(v[3])};
  endfunction

  typedef struct packed {
    logic [NI-1:0][2*DW-1:0] x;
    logic [NI-1:0][2*DW-1:0] y;
    logic [NI-1:0]           ov;
  } exp_t;

  exp_t q[$];

  // ---------------- compare process ----------------
  bit              prev_stall = 1'b0;
  bit              prev_clr = 1'b0;
  bit              model_ovf [NI];
  logic [2*DW-1:0] px [NI];
  logic [2*DW-1:0] py [NI];

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      prev_stall = 1'b0;
      prev_clr   = 1'b0;
      for (int k = 0; k < NI; k++) model_ovf[k] = 1'b0;
    end else begin
      for (int k = 0; k < NI; k++) begin
        check($sformatf("in_ready[%0d]", k), in_ready[k], !(out_valid[k] && !out_ready));
        if (prev_stall) begin
          check($sformatf("hold_valid[%0d]", k), out_valid[k], 1);
          check($sformatf("hold_x[%0d]", k), x[k], px[k]);
          check($sformatf("hold_y[%0d]", k), y[k], py[k]);
        end
        if (out_valid[k]) begin
          if (q.size() == 0) begin
            check($sformatf("spurious_out[%0d]", k), out_valid[k], 0);
          end else begin
            check($sformatf("x_re[%0d]", k), sx(x[k][2*DW-1:DW]), sx(q[0].x[k][2*DW-1:DW]));
            check($sformatf("x_im[%0d]", k), sx(x[k][DW-1:0]),    sx(q[0].x[k][DW-1:0]));
            check($sformatf("y_re[%0d]", k), sx(y[k][2*DW-1:DW]), sx(q[0].y[k][2*DW-1:DW]));
            check($sformatf("y_im[%0d]", k), sx(y[k][DW-1:0]),    sx(q[0].y[k][DW-1:0]));
          end
        end
        if (out_valid[k] && !prev_stall && q.size() > 0 && q[0].ov[k])
          model_ovf[k] = 1'b1;
        else if (prev_clr)
          model_ovf[k] = 1'b0;
        check($sformatf("ovf[%0d]", k), ovf[k], model_ovf[k]);
        px[k] = x[k];
        py[k] = y[k];
      end
      if (out_valid[2] && out_ready && q.size() > 0)
        void'(q.pop_front());
      if (in_valid && in_ready[2]) begin
        exp_t e;
        for (int k = 0; k < NI; k++) begin
          logic [2*DW-1:0] xo, yo;
          bit ov;
          model(sx(a[2*DW-1:DW]), sx(a[DW-1:0]), sx(b[2*DW-1:DW]), sx(b[DW-1:0]),
                longint'($signed(w_re)), longint'($signed(w_im)),
                mode, scale, k[0], k[1], xo, yo, ov);
          e.x[k]  = xo;
          e.y[k]  = yo;
          e.ov[k] = ov;
        end
        q.push_back(e);
      end
      prev_stall = out_valid[2] && !out_ready;
      prev_clr   = ovf_clr;
    end
  end

  // ---------------- out_ready driver ----------------
  bit rand_ready = 1'b0;
  initial forever begin
    @(posedge clk);
    #1;
    out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // ---------------- stimulus tasks ----------------
  logic [2*DW-1:0] snap_x [NI];
  logic [2*DW-1:0] snap_y [NI];
  logic            snap_ovf [NI];

  // Called at posedge+1; returns at posedge+1 just after the transfer edge.
  task automatic drive(input longint ar, ai, br, bi, wr, wi, input bit md, sc);
    int n;
    a        = {DW'(ar), DW'(ai)};
    b        = {DW'(br), DW'(bi)};
    w_re     = TW'(wr);
    w_im     = TW'(wi);
    mode     = md;
    scale    = sc;
    in_valid = 1'b1;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (in_ready[2]) break;
      n++;
    end
    if (n == 100) check("in_accept_timeout", in_ready[2], 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run1(input longint ar, ai, br, bi, wr, wi, input bit md, sc);
    int n;
    drive(ar, ai, br, bi, wr, wi, md, sc);
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (out_valid[2]) break;
    end
    check("latency", n, 3);
    for (int k = 0; k < NI; k++) begin
      snap_x[k]   = x[k];
      snap_y[k]   = y[k];
      snap_ovf[k] = ovf[k];
    end
    @(posedge clk);
    #1;
  endtask

  // Pins both the model and the captured DUT result to hand-computed values.
  task automatic chk(input string tag, input int k,
                     input longint ar, ai, br, bi, wr, wi, input bit md, sc,
                     input longint exr, exi, eyr, eyi);
    logic [2*DW-1:0] xo, yo;
    bit ov;
    model(ar, ai, br, bi, wr, wi, md, sc, k[0], k[1], xo, yo, ov);
    check({tag, "_model_x_re"}, sx(xo[2*DW-1:DW]), exr);
    check({tag, "_model_x_im"}, sx(xo[DW-1:0]), exi);
    check({tag, "_model_y_re"}, sx(yo[2*DW-1:DW]), eyr);
    check({tag, "_model_y_im"}, sx(yo[DW-1:0]), eyi);
    check({tag, "_x_re"}, sx(snap_x[k][2*DW-1:DW]), exr);
    check({tag, "_x_im"}, sx(snap_x[k][DW-1:0]), exi);
    check({tag, "_y_re"}, sx(snap_y[k][2*DW-1:DW]), eyr);
    check({tag, "_y_im"}, sx(snap_y[k][DW-1:0]), eyi);
  endtask

  function automatic longint rcomp();
    logic [DW-1:0] t;
    t = DW'($urandom);
    return sx(t);
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      check($sformatf("rst_out_valid[%0d]", k), out_valid[k], 0);
      check($sformatf("rst_x[%0d]", k), x[k], 0);
      check($sformatf("rst_y[%0d]", k), y[k], 0);
      check($sformatf("rst_ovf[%0d]", k), ovf[k], 0);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;

    // DIF and DIT with W = -j
    run1(100, 50, 20, 10, 0, -65536, 1'b0, 1'b0);
    chk("dif", 2, 100, 50, 20, 10, 0, -65536, 1'b0, 1'b0, 120, 60, 40, -80);
    run1(100, 50, 20, 10, 0, -65536, 1'b1, 1'b0);
    chk("dit", 2, 100, 50, 20, 10, 0, -65536, 1'b1, 1'b0, 110, 30, 90, 70);
    check("dit_ovf", snap_ovf[2], 0);

    // Saturation vs wrap, then clear
    run1(32767, 0, 1, 0, 65536, 0, 1'b0, 1'b0);
    chk("sat", 2, 32767, 0, 1, 0, 65536, 0, 1'b0, 1'b0, 32767, 0, 32766, 0);
    chk("wrap", 0, 32767, 0, 1, 0, 65536, 0, 1'b0, 1'b0, -32768, 0, 32766, 0);
    check("sat_ovf", snap_ovf[2], 1);
    check("wrap_ovf", snap_ovf[0], 1);
    ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    ovf_clr = 1'b0;
    for (int k = 0; k < NI; k++)
      check($sformatf("ovf_cleared[%0d]", k), ovf[k], 0);

    // Rounding of the twiddle product and of the scale shift
    run1(3, -3, 0, 0, 32768, 0, 1'b0, 1'b0);
    chk("trunc", 2, 3, -3, 0, 0, 32768, 0, 1'b0, 1'b0, 3, -3, 1, -2);
    chk("round", 3, 3, -3, 0, 0, 32768, 0, 1'b0, 1'b0, 3, -3, 2, -1);
    run1(5, 0, 1, 0, 32768, 0, 1'b0, 1'b1);
    chk("scale", 2, 5, 0, 1, 0, 32768, 0, 1'b0, 1'b1, 3, 0, 1, 0);

    // Backpressure stream
    rand_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      drive(rcomp(), rcomp(), rcomp(), rcomp(),
            longint'($urandom_range(0, 262143)) - 131072,
            longint'($urandom_range(0, 262143)) - 131072,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    n = 0;
    while (n < 300 && q.size() != 0) begin
      @(negedge clk);
      n++;
    end
    check("stream_drain", q.size(), 0);
    @(posedge clk);
    #1;
    rand_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset with three butterflies in flight
    a        = {16'sd100, 16'sd50};
    b        = {16'sd20, 16'sd10};
    w_re     = '0;
    w_im     = TW'(-65536);
    mode     = 1'b0;
    scale    = 1'b0;
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      check($sformatf("midrst_out_valid[%0d]", k), out_valid[k], 0);
      check($sformatf("midrst_x[%0d]", k), x[k], 0);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    run1(100, 50, 20, 10, 0, -65536, 1'b1, 1'b0);
    chk("post_rst", 2, 100, 50, 20, 10, 0, -65536, 1'b1, 1'b0, 110, 30, 90, 70);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
